// File: rtl/vec_mul_job_ctrl_pkg.sv
// Shared definitions for the vector-multiplier job sequencer.
package vec_mul_pkg;

  // 3-bit state encodings for the job sequencer
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_WADDR_ENC  = 3'd1;
  localparam logic [2:0] ST_WLOAD_ENC  = 3'd2;
  localparam logic [2:0] ST_STREAM_ENC = 3'd3;
  localparam logic [2:0] ST_DRAIN_ENC  = 3'd4;
  localparam logic [2:0] ST_DONE_ENC   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_WADDR  = ST_WADDR_ENC,
    S_WLOAD  = ST_WLOAD_ENC,
    S_STREAM = ST_STREAM_ENC,
    S_DRAIN  = ST_DRAIN_ENC,
    S_DONE   = ST_DONE_ENC
  } state_e;

  // Index/length width: one extra bit so a full 2^addr_w job length is representable
  function automatic int unsigned idx_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/vec_mul_job_ctrl_if.sv
// Host control and memory-side signals of the job sequencer.
interface vec_mul_job_ctrl_if #(
  parameter int unsigned ADDRESSSIZE   = 10,
  parameter int unsigned ADDRESSSIZE_W = 2
);

  logic                     start;
  logic [ADDRESSSIZE-1:0]   cfg_src_base;
  logic [ADDRESSSIZE-1:0]   cfg_dst_base;
  logic [ADDRESSSIZE:0]     cfg_len;
  logic [ADDRESSSIZE_W-1:0] cfg_wsel;

  logic                     busy;
  logic                     done;
  logic                     err;
  logic [ADDRESSSIZE-1:0]   ub_addr;
  logic                     ub_rd_en;
  logic [ADDRESSSIZE_W-1:0] w_addr;
  logic                     weight_reload;
  logic                     res_we;
  logic [ADDRESSSIZE-1:0]   res_addr;

  // Host side: issues jobs, observes status and memory strobes
  modport master (
    output start, cfg_src_base, cfg_dst_base, cfg_len, cfg_wsel,
    input  busy, done, err, ub_addr, ub_rd_en, w_addr, weight_reload, res_we, res_addr
  );

  // Sequencer side
  modport slave (
    input  start, cfg_src_base, cfg_dst_base, cfg_len, cfg_wsel,
    output busy, done, err, ub_addr, ub_rd_en, w_addr, weight_reload, res_we, res_addr
  );

endinterface

// File: rtl/vec_mul_job_ctrl_valid_delay_line.sv
// Registered {valid, data} shift chain aligning result writes to array latency.
// Each stage's data only loads when a valid entry arrives, so the output data
// holds the last written address while valid is low.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pending_o
);

  logic             vin     [DEPTH];
  logic [WIDTH-1:0] din     [DEPTH];
  logic             vld_q   [DEPTH];
  logic [WIDTH-1:0] dat_q   [DEPTH];
  logic [DEPTH-1:0] vld_vec;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = valid_i;
      assign din[k] = data_i;
    end else begin : g_tail
      assign vin[k] = vld_q[k-1];
      assign din[k] = dat_q[k-1];
    end

    assign vld_vec[k] = vld_q[k];

    // Stage k: valid always shifts, data loads only with a valid entry
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= '0;
      end else begin
        vld_q[k] <= vin[k];
        if (vin[k]) begin
          dat_q[k] <= din[k];
        end
      end
    end
  end

  // Pending = an entry still travelling toward the output stage
  if (DEPTH > 1) begin : g_pend
    assign pending_o = |vld_vec[DEPTH-2:0];
  end else begin : g_nopend
    assign pending_o = 1'b0;
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/vec_mul_job_ctrl.sv
// Job sequencer for the vector-multiplier datapath: weight tile reload,
// input vector streaming from the UB and latency-aligned result writes.
module vec_mul_job_ctrl
  import vec_mul_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE   = 10,
  parameter int unsigned ADDRESSSIZE_W = 2,
  parameter int unsigned PIPE_LAT      = 1
) (
  input  logic              clk,
  input  logic              rstn,
  vec_mul_job_ctrl_if.slave bus
);

  localparam int unsigned     IDX_W   = idx_width(ADDRESSSIZE);
  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(1) << ADDRESSSIZE;

  state_e                   state_q, state_d;
  logic [ADDRESSSIZE-1:0]   src_q, src_d;
  logic [ADDRESSSIZE-1:0]   dst_q, dst_d;
  logic [IDX_W-1:0]         len_q, len_d;
  logic [ADDRESSSIZE_W-1:0] wsel_q, wsel_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [ADDRESSSIZE-1:0]   ub_addr_q, ub_addr_d;
  logic                     ub_rd_en_q, ub_rd_en_d;
  logic [ADDRESSSIZE_W-1:0] w_addr_q, w_addr_d;
  logic                     weight_reload_q, weight_reload_d;

  logic                     cfg_legal_c;
  logic [ADDRESSSIZE-1:0]   res_addr_in_c;
  logic                     dl_pending;
  logic                     dl_valid;
  logic [ADDRESSSIZE-1:0]   dl_addr;

  assign cfg_legal_c   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
  // Result address travels with the vector currently on ub_addr
  assign res_addr_in_c = dst_q + cnt_q[ADDRESSSIZE-1:0];

  // Next state, latched job config and next output values
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    len_d           = len_q;
    wsel_d          = wsel_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    w_addr_d        = w_addr_q;
    ub_addr_d       = ub_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_legal_c) begin
            src_d   = bus.cfg_src_base;
            dst_d   = bus.cfg_dst_base;
            len_d   = bus.cfg_len;
            wsel_d  = bus.cfg_wsel;
            err_d   = 1'b0;
            state_d = S_WADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WADDR: state_d = S_WLOAD;
      S_WLOAD: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (cnt_q == len_q - IDX_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (!dl_pending) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start while a job runs is flagged but otherwise ignored
    if (bus.start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    weight_reload_d = (state_d == S_WLOAD);
    ub_rd_en_d      = (state_d == S_STREAM);

    if (state_d == S_WADDR) begin
      w_addr_d = wsel_d;
    end
    if (ub_rd_en_d) begin
      ub_addr_d = src_q + cnt_d[ADDRESSSIZE-1:0];
    end
  end

  // State, config and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      src_q           <= '0;
      dst_q           <= '0;
      len_q           <= '0;
      wsel_q          <= '0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      ub_addr_q       <= '0;
      ub_rd_en_q      <= 1'b0;
      w_addr_q        <= '0;
      weight_reload_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      len_q           <= len_d;
      wsel_q          <= wsel_d;
      cnt_q           <= cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      ub_addr_q       <= ub_addr_d;
      ub_rd_en_q      <= ub_rd_en_d;
      w_addr_q        <= w_addr_d;
      weight_reload_q <= weight_reload_d;
    end
  end

  valid_delay_line #(
    .DEPTH (PIPE_LAT + 1),
    .WIDTH (ADDRESSSIZE)
  ) u_delay (
    .clk       (clk),
    .rstn      (rstn),
    .valid_i   (ub_rd_en_q),
    .data_i    (res_addr_in_c),
    .valid_o   (dl_valid),
    .data_o    (dl_addr),
    .pending_o (dl_pending)
  );

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.ub_addr       = ub_addr_q;
  assign bus.ub_rd_en      = ub_rd_en_q;
  assign bus.w_addr        = w_addr_q;
  assign bus.weight_reload = weight_reload_q;
  assign bus.res_we        = dl_valid;
  assign bus.res_addr      = dl_addr;

endmodule

// File: tb/tb_vec_mul_job_ctrl.sv
// Directed bench for vec_mul_job_ctrl at PIPE_LAT = 0, 1 and 3.
module tb_vec_mul_job_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned WW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic [WW-1:0] wsel;
  logic [1:0]    sel;

  int n_asserts = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  vec_mul_job_ctrl_if #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW)) if_pl0 ();
  vec_mul_job_ctrl_if #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW)) if_pl1 ();
  vec_mul_job_ctrl_if #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW)) if_pl3 ();

  assign if_pl0.start = start && (sel == 2'd0);
  assign if_pl1.start = start && (sel == 2'd1);
  assign if_pl3.start = start && (sel == 2'd2);
  assign if_pl0.cfg_src_base = src;  assign if_pl1.cfg_src_base = src;  assign if_pl3.cfg_src_base = src;
  assign if_pl0.cfg_dst_base = dst;  assign if_pl1.cfg_dst_base = dst;  assign if_pl3.cfg_dst_base = dst;
  assign if_pl0.cfg_len      = len;  assign if_pl1.cfg_len      = len;  assign if_pl3.cfg_len      = len;
  assign if_pl0.cfg_wsel     = wsel; assign if_pl1.cfg_wsel     = wsel; assign if_pl3.cfg_wsel     = wsel;

  vec_mul_job_ctrl #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW), .PIPE_LAT(0)) u_dut_pl0 (
    .clk(clk), .rstn(rstn), .bus(if_pl0));
  vec_mul_job_ctrl #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW), .PIPE_LAT(1)) u_dut_pl1 (
    .clk(clk), .rstn(rstn), .bus(if_pl1));
  vec_mul_job_ctrl #(.ADDRESSSIZE(AW), .ADDRESSSIZE_W(WW), .PIPE_LAT(3)) u_dut_pl3 (
    .clk(clk), .rstn(rstn), .bus(if_pl3));

  logic          o_busy, o_done, o_err, o_rd_en, o_wr, o_we;
  logic [AW-1:0] o_ub_addr, o_res_addr;
  logic [WW-1:0] o_w_addr;

  // Observe the outputs of the DUT currently under test
  always_comb begin
    o_busy = if_pl1.busy; o_done = if_pl1.done; o_err = if_pl1.err;
    o_rd_en = if_pl1.ub_rd_en; o_wr = if_pl1.weight_reload; o_we = if_pl1.res_we;
    o_ub_addr = if_pl1.ub_addr; o_res_addr = if_pl1.res_addr; o_w_addr = if_pl1.w_addr;
    if (sel == 2'd0) begin
      o_busy = if_pl0.busy; o_done = if_pl0.done; o_err = if_pl0.err;
      o_rd_en = if_pl0.ub_rd_en; o_wr = if_pl0.weight_reload; o_we = if_pl0.res_we;
      o_ub_addr = if_pl0.ub_addr; o_res_addr = if_pl0.res_addr; o_w_addr = if_pl0.w_addr;
    end else if (sel == 2'd2) begin
      o_busy = if_pl3.busy; o_done = if_pl3.done; o_err = if_pl3.err;
      o_rd_en = if_pl3.ub_rd_en; o_wr = if_pl3.weight_reload; o_we = if_pl3.res_we;
      o_ub_addr = if_pl3.ub_addr; o_res_addr = if_pl3.res_addr; o_w_addr = if_pl3.w_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},     32'(o_busy),     32'd0);
    chk({tag, " done"},     32'(o_done),     32'd0);
    chk({tag, " err"},      32'(o_err),      32'd0);
    chk({tag, " ub_rd_en"}, 32'(o_rd_en),    32'd0);
    chk({tag, " ub_addr"},  32'(o_ub_addr),  32'd0);
    chk({tag, " w_addr"},   32'(o_w_addr),   32'd0);
    chk({tag, " wreload"},  32'(o_wr),       32'd0);
    chk({tag, " res_we"},   32'(o_we),       32'd0);
    chk({tag, " res_addr"}, 32'(o_res_addr), 32'd0);
  endtask

  // Start a job in the current cycle (cycle 0) and check every cycle up to the
  // first idle cycle after done. inj > 0 pulses start again at that cycle.
  task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                         input logic [WW-1:0] ws, input int pl, input int inj);
    int            last_c;
    int            k;
    logic [AW-1:0] ea;
    last_c = n + 5 + pl;
    src = s; dst = d; len = (AW+1)'(n); wsel = ws; start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step();
      start = (c == inj);
      if (c == 1) begin
        src = ~s; dst = ~d; len = 11'd7; wsel = ~ws;
      end
      chk($sformatf("busy c%0d", c),    32'(o_busy),  32'(c <= n + 4 + pl));
      chk($sformatf("done c%0d", c),    32'(o_done),  32'(c == n + 4 + pl));
      chk($sformatf("err c%0d", c),     32'(o_err),   32'(inj > 0 && c > inj));
      chk($sformatf("w_addr c%0d", c),  32'(o_w_addr), 32'(ws));
      chk($sformatf("wreload c%0d", c), 32'(o_wr),    32'(c == 2));
      chk($sformatf("ub_rd_en c%0d", c), 32'(o_rd_en), 32'(c >= 3 && c <= n + 2));
      chk($sformatf("res_we c%0d", c),  32'(o_we),    32'(c >= 4 + pl && c <= n + 3 + pl));
      if (c >= 3) begin
        k  = (c - 3 < n - 1) ? c - 3 : n - 1;
        ea = s + AW'(k);
        chk($sformatf("ub_addr c%0d", c), 32'(o_ub_addr), 32'(ea));
      end
      if (c >= 4 + pl) begin
        k  = (c - 4 - pl < n - 1) ? c - 4 - pl : n - 1;
        ea = d + AW'(k);
        chk($sformatf("res_addr c%0d", c), 32'(o_res_addr), 32'(ea));
      end
    end
  endtask

  initial begin
    sel = 2'd1; start = 1'b0; src = '0; dst = '0; len = '0; wsel = '0;
    rstn = 1'b0;
    #12;
    chk_all_zero("reset");
    rstn = 1'b1;
    step();

    // Basic job, then a wrapping job back-to-back in the idle cycle after done
    run_job(10'd0, 10'd0, 4, 2'd2, 1, 0);
    run_job(10'd1022, 10'd1023, 3, 2'd1, 1, 0);
    step();

    // Illegal lengths: flagged, no activity
    len = 11'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0 err", 32'(o_err), 32'd1);
    chk("len0 busy", 32'(o_busy), 32'd0);
    chk("len0 ub_rd_en", 32'(o_rd_en), 32'd0);
    chk("len0 wreload", 32'(o_wr), 32'd0);
    step();
    chk("len0 err sticky", 32'(o_err), 32'd1);
    chk("len0 busy later", 32'(o_busy), 32'd0);
    chk("len0 res_we", 32'(o_we), 32'd0);
    len = 11'd1025; start = 1'b1;
    step();
    start = 1'b0;
    chk("len1025 err", 32'(o_err), 32'd1);
    chk("len1025 busy", 32'(o_busy), 32'd0);
    step();
    run_job(10'd5, 10'd9, 2, 2'd3, 1, 0);
    step();

    // Start pulsed mid-job is flagged and ignored
    run_job(10'd100, 10'd200, 8, 2'd1, 1, 5);
    step();

    // Reset during STREAM after two vectors issued
    src = 10'd0; dst = 10'd0; len = 11'd8; wsel = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre-reset ub_addr", 32'(o_ub_addr), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    #2 rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post-reset res_we %0d", c), 32'(o_we), 32'd0);
      chk($sformatf("post-reset done %0d", c), 32'(o_done), 32'd0);
      chk($sformatf("post-reset busy %0d", c), 32'(o_busy), 32'd0);
    end
    run_job(10'd0, 10'd0, 4, 2'd2, 1, 0);
    step();

    // PIPE_LAT = 0: single vectors back-to-back, then a full-range job
    sel = 2'd0;
    step();
    run_job(10'd7, 10'd8, 1, 2'd1, 0, 0);
    run_job(10'd1023, 10'd1023, 1, 2'd3, 0, 0);
    step();
    run_job(10'd512, 10'd3, 1024, 2'd0, 0, 0);
    step();

    // PIPE_LAT = 3: single vectors back-to-back
    sel = 2'd2;
    step();
    run_job(10'd10, 10'd20, 1, 2'd2, 3, 0);
    run_job(10'd11, 10'd21, 1, 2'd1, 3, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, fails);
    $finish;
  end

endmodule
